// File: rtl/core_pkg.sv
// Shared types and helpers for the multicore data-memory front end.
package core_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
import core_pkg::*;

module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] id
);

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        id     = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// N-core shared data-memory front end, one transaction in flight.
import core_pkg::*;

module core_mem_arbiter #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES-1:0]        core_rd,
  input  logic [N_CORES-1:0]        core_wr,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*DATA_W-1:0] core_wdata,
  output logic [N_CORES-1:0]        core_ack,
  output logic [N_CORES*DATA_W-1:0] core_rdata,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      proto_err
);

  localparam int IDW = clog2(N_CORES);
  localparam int CW  = 4;

  state_t             st;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     win;
  logic [N_CORES-1:0] win_oh;
  logic               op;
  logic [CW-1:0]      cnt;

  logic [N_CORES-1:0] req;
  logic [N_CORES-1:0] gnt;
  logic [IDW-1:0]     gid;

  assign req = core_rd | core_wr;

  rr_arbiter #(
    .N   (N_CORES),
    .IDW (IDW)
  ) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .id  (gid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      rr_ptr     <= '0;
      win        <= '0;
      win_oh     <= '0;
      op         <= OP_RD;
      cnt        <= '0;
      core_ack   <= '0;
      core_rdata <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      proto_err  <= 1'b0;
    end else begin
      core_ack <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      if (|(core_rd & core_wr)) proto_err <= 1'b1;
      unique case (st)
        S_IDLE: begin
          if (|req) begin
            win       <= gid;
            win_oh    <= gnt;
            op        <= core_wr[gid];
            mem_addr  <= core_addr[int'(gid)*ADDR_W +: ADDR_W];
            mem_wdata <= core_wdata[int'(gid)*DATA_W +: DATA_W];
            rr_ptr    <= (gid == IDW'(N_CORES-1)) ? '0 : gid + 1'b1;
            mem_wr    <= core_wr[gid];
            mem_rd    <= ~core_wr[gid];
            st        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op == OP_WR) begin
            core_ack <= win_oh;
            st       <= S_ACK;
          end else begin
            cnt <= CW'(RD_LAT-1);
            st  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // cnt reaches 0 in the cycle mem_rdata is valid
          if (cnt == '0) begin
            core_rdata[int'(win)*DATA_W +: DATA_W] <= mem_rdata;
            core_ack <= win_oh;
            st       <= S_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ACK:   st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
